atomic_unit: RTL and testbench

ATOMIC_UNIT -- requirements
Module: atomic_unit

---
 rtl/atomic_unit.sv | 139 +++++++++++++
 tb/tb_atomic_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomic_unit.sv
// RV32A atomic memory unit: sequences LR, SC and read-modify-write AMOs
// over a simple request/ready memory port and a reservation-check port.
module atomic_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] src,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            lr_valid,
  output logic [XLEN-1:0] lr_addr,
  output logic            sc_valid,
  output logic [XLEN-1:0] sc_addr,
  input  logic            sc_success,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {IDLE, READ, SC_CHECK, WRITE, DONE} state_t;
  typedef enum logic [3:0] {
    OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
    OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_ILL
  } op_t;

  state_t          state_q, state_d;
  op_t             dec_op, op_q;
  logic            bad;
  logic [XLEN-1:0] addr_q, src_q, wdata_q, amo_new;

  always_comb begin
    dec_op = OP_ILL;
    case (funct5)
      5'b00010: dec_op = OP_LR;
      5'b00011: dec_op = OP_SC;
      5'b00001: dec_op = OP_SWAP;
      5'b00000: dec_op = OP_ADD;
      5'b00100: dec_op = OP_XOR;
      5'b01100: dec_op = OP_AND;
      5'b01000: dec_op = OP_OR;
      5'b10000: dec_op = OP_MIN;
      5'b10100: dec_op = OP_MAX;
      5'b11000: dec_op = OP_MINU;
      5'b11100: dec_op = OP_MAXU;
      default:  dec_op = OP_ILL;
    endcase
  end

  assign bad = (dec_op == OP_ILL) || (addr[1:0] != 2'b00);

  // New memory value from old (mem_rdata) and src; ties keep old.
  always_comb begin
    amo_new = src_q;
    case (op_q)
      OP_ADD:  amo_new = mem_rdata + src_q;
      OP_XOR:  amo_new = mem_rdata ^ src_q;
      OP_AND:  amo_new = mem_rdata & src_q;
      OP_OR:   amo_new = mem_rdata | src_q;
      OP_MIN:  amo_new = ($signed(src_q) < $signed(mem_rdata)) ? src_q : mem_rdata;
      OP_MAX:  amo_new = ($signed(src_q) > $signed(mem_rdata)) ? src_q : mem_rdata;
      OP_MINU: amo_new = (src_q < mem_rdata) ? src_q : mem_rdata;
      OP_MAXU: amo_new = (src_q > mem_rdata) ? src_q : mem_rdata;
      default: amo_new = src_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad)                  state_d = DONE;
          else if (dec_op == OP_SC) state_d = SC_CHECK;
          else                      state_d = READ;
        end
      end
      READ:     if (mem_ready) state_d = (op_q == OP_LR) ? DONE : WRITE;
      SC_CHECK: state_d = sc_success ? WRITE : DONE;
      WRITE:    if (mem_ready) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ILL;
      addr_q  <= '0;
      src_q   <= '0;
      wdata_q <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        op_q    <= dec_op;
        addr_q  <= addr;
        src_q   <= src;
        wdata_q <= src;
        result  <= '0;
        err     <= bad;
      end
      if (state_q == READ && mem_ready) begin
        result <= mem_rdata;
        if (op_q != OP_LR) wdata_q <= amo_new;
      end
      if (state_q == SC_CHECK) result <= sc_success ? '0 : {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  // Memory handshake: mem_req with mem_we/mem_addr/mem_wdata is held steady
  // until the cycle mem_ready=1, which completes the access; ready without req is ignored.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_req   = (state_q == READ) || (state_q == WRITE);
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign lr_valid  = (state_q == READ) && mem_ready && (op_q == OP_LR);
  assign lr_addr   = addr_q;
  assign sc_valid  = (state_q == SC_CHECK);
  assign sc_addr   = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit: a memory responder with programmable stalls,
// a behavioural model predicting each operation, and a per-cycle compare process.
module tb_atomic_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  funct5;
  logic [31:0] addr, src;
  logic        busy, done, err;
  logic [31:0] result;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        lr_valid, sc_valid;
  logic [31:0] lr_addr, sc_addr;
  logic        sc_success;
  logic [2:0]  dbg_state;

  atomic_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr), .src(src),
    .busy(busy), .done(done), .err(err), .result(result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .lr_valid(lr_valid), .lr_addr(lr_addr), .sc_valid(sc_valid), .sc_addr(sc_addr),
    .sc_success(sc_success), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment memory (written by the DUT) and the model's own copy.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Responder: each new access phase stalls for rd_stall/wr_stall cycles.
  int rd_stall = 0, wr_stall = 0, wait_cnt = 0;
  bit prev_req = 0, prev_we = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!prev_req || prev_we != mem_we) wait_cnt = mem_we ? wr_stall : rd_stall;
      if (wait_cnt > 0) begin
        mem_ready = 1'b0;
        wait_cnt--;
      end else mem_ready = 1'b1;
    end else mem_ready = 1'b1;
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    prev_req = mem_req;
    prev_we  = mem_we;
  end

  // Model expectations
  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];
  int          exp_lat_q[$];
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  int          exp_nacc, exp_nlr, exp_nsc;
  logic [31:0] exp_raddr;

  task automatic predict(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] s,
                         input bit ok, input int rs, input int ws);
    logic [31:0] old, nv, res;
    bit legal, amo, wr;
    int lat, nacc, nlr, nsc, so, ss;
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    so = old; ss = s;
    legal = 1; amo = 1; wr = 0; nv = s; res = 0; lat = 0; nacc = 0; nlr = 0; nsc = 0;
    case (f5)
      5'b00010: begin amo = 0; res = old; lat = 2 + rs; nacc = 1; nlr = 1; end
      5'b00011: begin
        amo = 0; nsc = 1;
        if (ok) begin res = 0; wr = 1; lat = 3 + ws; nacc = 1; end
        else    begin res = 1; lat = 2; end
      end
      5'b00001: nv = s;
      5'b00000: nv = old + s;
      5'b00100: nv = old ^ s;
      5'b01100: nv = old & s;
      5'b01000: nv = old | s;
      5'b10000: nv = (ss < so) ? s : old;
      5'b10100: nv = (ss > so) ? s : old;
      5'b11000: nv = ({32'h0, s} < {32'h0, old}) ? s : old;
      5'b11100: nv = ({32'h0, s} > {32'h0, old}) ? s : old;
      default:  legal = 0;
    endcase
    if (legal && amo) begin res = old; wr = 1; lat = 3 + rs + ws; nacc = 2; end
    if (!legal || a[1:0] != 2'b00) begin
      res = 0; wr = 0; lat = 1; nacc = 0; nlr = 0; nsc = 0;
      exp_err_q.push_back(1);
    end else exp_err_q.push_back(0);
    exp_q.push_back(res);
    exp_lat_q.push_back(lat);
    if (wr) begin
      ref_mem[a] = nv;
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(nv);
    end
    exp_nacc = nacc; exp_nlr = nlr; exp_nsc = nsc; exp_raddr = a;
  endtask

  // Compare process
  int acc_cnt = 0, req_cyc = 0, lr_cnt = 0, sc_cnt = 0, t_start = 0, done_cnt = 0;
  bit prev_stall = 0;
  logic [31:0] p_addr, p_wdata, last_res, last_wd;
  logic p_we;
  always @(negedge clk) begin
    #2;
    if (reset) prev_stall = 0;
    else begin
      if (start && !busy) begin
        acc_cnt = 0; req_cyc = 0; lr_cnt = 0; sc_cnt = 0; t_start = cyc;
      end
      chk("lr_sc_excl", {31'h0, lr_valid & sc_valid}, 32'h0);
      if (prev_stall) begin
        chk("stall_req", {31'h0, mem_req}, 32'h1);
        chk("stall_we", {31'h0, mem_we}, {31'h0, p_we});
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_wdata", mem_wdata, p_wdata);
      end
      prev_stall = mem_req && !mem_ready;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      if (mem_req) req_cyc++;
      if (mem_req && mem_ready) begin
        acc_cnt++;
        if (mem_we) begin
          if (exp_wa_q.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
          else begin
            chk("wr_addr", mem_addr, exp_wa_q.pop_front());
            chk("wr_data", mem_wdata, exp_wd_q.pop_front());
          end
          mem[mem_addr] = mem_wdata;
          last_wd = mem_wdata;
        end
      end
      if (lr_valid) begin lr_cnt++; chk("lr_addr", lr_addr, exp_raddr); end
      if (sc_valid) begin sc_cnt++; chk("sc_addr", sc_addr, exp_raddr); end
      if (done) begin
        done_cnt++;
        last_res = result;
        if (exp_q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
        else begin
          chk("result", result, exp_q.pop_front());
          chk("err", {31'h0, err}, exp_err_q.pop_front());
          chk("latency", cyc - t_start, exp_lat_q.pop_front());
          chk("accesses", acc_cnt, exp_nacc);
          chk("lr_pulses", lr_cnt, exp_nlr);
          chk("sc_pulses", sc_cnt, exp_nsc);
          if (exp_nacc == 0) chk("no_mem_req", req_cyc, 0);
        end
      end
    end
  end

  task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] s,
                        input bit ok, input int rs, input int ws, input bit poke,
                        input logic [31:0] lit_res, input bit lit_hw, input logic [31:0] lit_wd);
    int d0;
    predict(f5, a, s, ok, rs, ws);
    @(negedge clk);
    rd_stall = rs; wr_stall = ws; sc_success = ok;
    funct5 = f5; addr = a; src = s; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0; funct5 = 5'b0; addr = 32'h0; src = 32'h0;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; funct5 = 5'b11111; addr = 32'h3; src = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; funct5 = 5'b0; addr = 32'h0; src = 32'h0;
    end
    for (int i = 0; i < 60 && done_cnt == d0; i++) @(posedge clk);
    chk("done_seen", {31'h0, done_cnt != d0}, 32'h1);
    repeat (2) @(posedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("lit_result", last_res, lit_res);
    if (lit_hw) chk("lit_wdata", last_wd, lit_wd);
  endtask

  initial begin
    int d0;
    start = 0; funct5 = 0; addr = 0; src = 0; sc_success = 0;
    mem_ready = 1; mem_rdata = 0;
    mem[32'h100] = 32'h5;        ref_mem[32'h100] = 32'h5;
    mem[32'h200] = 32'hAA;       ref_mem[32'h200] = 32'hAA;
    mem[32'h300] = 32'hFFFF_FFFF; ref_mem[32'h300] = 32'hFFFF_FFFF;
    mem[32'h304] = 32'hFFFF_FFFF; ref_mem[32'h304] = 32'hFFFF_FFFF;
    mem[32'h400] = 32'h0F0F_1234; ref_mem[32'h400] = 32'h0F0F_1234;
    reset = 0;
    #1 reset = 1;
    #1;
    chk("rst_flags", {25'h0, busy, done, err, mem_req, mem_we, lr_valid, sc_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_state", {29'h0, dbg_state}, 32'h0);

    run_op(5'b00000, 32'h100, 32'h3, 0, 0, 0, 0, 32'h5, 1, 32'h8);
    chk("amoadd_mem", mem[32'h100], 32'h8);
    run_op(5'b00010, 32'h200, 32'h0, 0, 0, 0, 0, 32'hAA, 0, 32'h0);
    run_op(5'b00011, 32'h200, 32'h55, 1, 0, 0, 0, 32'h0, 1, 32'h55);
    run_op(5'b00011, 32'h200, 32'h66, 0, 0, 0, 0, 32'h1, 0, 32'h0);
    chk("sc_mem", mem[32'h200], 32'h55);
    run_op(5'b10000, 32'h300, 32'h1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    run_op(5'b11000, 32'h304, 32'h1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h1);
    run_op(5'b00001, 32'h400, 32'h1234_5678, 0, 0, 0, 0, 32'h0F0F_1234, 1, 32'h1234_5678);
    run_op(5'b00100, 32'h400, 32'hFFFF_0000, 0, 0, 0, 0, 32'h1234_5678, 1, 32'hEDCB_5678);
    run_op(5'b01100, 32'h400, 32'h0000_FFFF, 0, 0, 0, 0, 32'hEDCB_5678, 1, 32'h0000_5678);
    run_op(5'b01000, 32'h400, 32'hA000_0000, 0, 0, 0, 0, 32'h0000_5678, 1, 32'hA000_5678);
    run_op(5'b10100, 32'h400, 32'h10, 0, 0, 0, 0, 32'hA000_5678, 1, 32'h10);
    run_op(5'b11100, 32'h400, 32'h20, 0, 0, 0, 0, 32'h10, 1, 32'h20);
    run_op(5'b00000, 32'h400, 32'hFFFF_FFF0, 0, 4, 2, 1, 32'h20, 1, 32'h10);
    run_op(5'b10000, 32'h400, 32'h10, 0, 0, 0, 0, 32'h10, 1, 32'h10);
    run_op(5'b00000, 32'h102, 32'h1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    run_op(5'b11111, 32'h100, 32'h1, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Reset in the middle of a stalled write: no done, all outputs cleared.
    @(negedge clk);
    rd_stall = 0; wr_stall = 20;
    funct5 = 5'b00000; addr = 32'h100; src = 32'h1; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 10 && !mem_we; i++) @(posedge clk);
    chk("reached_write", {31'h0, mem_we}, 32'h1);
    #2 reset = 1;
    #1;
    chk("midrst_flags", {25'h0, busy, done, err, mem_req, mem_we, lr_valid, sc_valid}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_mem_wdata", mem_wdata, 32'h0);
    chk("midrst_lr_addr", lr_addr, 32'h0);
    chk("midrst_sc_addr", sc_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    wr_stall = 0;

    run_op(5'b00010, 32'h100, 32'h0, 0, 3, 0, 0, 32'h8, 0, 32'h0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
